branch_stage_n: RTL and testbench
=================================

Name: branch_stage_n

Overview:
- Parametrised, single-clock successor of the join-pipeline branch stage.
- Accepts one packet per cycle and looks up a match flag (MF) for the packet's destination in a runtime-writable SubPS table.
- Overwrites the MF bit in the packet and routes it to one of NCH output channels, selected by a packet field.
- Channel handshakes are level Send/Ack, with one output register of buffering.

Parameters:
PW, 38, packet width in bits
DEST_LSB, 20, LSB of destination field
TBL_AW, 6, SubPS address width; depth 2**TBL_AW; index = PACKET_IN[DEST_LSB+TBL_AW-1:DEST_LSB]
SEL_LSB, 18, LSB of route-select field
SEL_W, 1, route-select width
NCH, 2, output channel count, 2..2**SEL_W
MF_BIT, 18, bit position overwritten with MF in the output packet

Ports:
CP  in  1  clock, rising edge
MR  in  1  master reset; synchronous, active-low (sampled at posedge CP; 0 = reset)
PACKET_IN  in  PW  input packet
Send_in  in  1  input valid
Ack_out  out  1  input ready; transfer occurs when Send_in & Ack_out at posedge CP
PACKET_OUT  out  PW  registered output packet, common to all channels
Send_out  out  NCH  one-hot output valid
Ack_in  in  NCH  per-channel ready
TBL_WE  in  1  SubPS write enable
TBL_WADDR  in  TBL_AW  SubPS write address
TBL_WDATA  in  1  SubPS write data
DROP_CNT  out  16  count of discarded packets, saturating

Behaviour:
- Reset (MR=0 at posedge CP):
  - All SubPS entries cleared to 0.
  - Output register invalid; Send_out=0; PACKET_OUT=0; DROP_CNT=0.
  - Reset overrides any same-cycle transfer or table write.
  - A packet held mid-transfer at reset is lost and is not counted.
- Definitions:
  - sel = PACKET_IN[SEL_LSB+SEL_W-1:SEL_LSB]
  - V = output-register valid
  - ch = stored channel
  - drain = V & Ack_in[ch]
- Ack_out = MR & (~V | drain). Ack_out is combinational, so full throughput holds when downstream is ready every cycle.
- On accept with sel < NCH:
  - V<=1; ch<=sel.
  - PACKET_OUT <= PACKET_IN with bit MF_BIT replaced by MF.
  - Latency: 1 cycle from accept edge to Send_out.
- On accept with sel >= NCH (only possible if NCH < 2**SEL_W):
  - Packet is discarded and V is cleared (or stays 0).
  - DROP_CNT increments, saturating at 16'hFFFF.
- Drain without accept: V<=0. Drain with same-edge accept: the register reloads, giving no bubble.
- Send_out[k] = V & (ch==k). At most one bit is high.
- While Send_out[k]=1 and Ack_in[k]=0, PACKET_OUT and Send_out hold stable.
- Ack_in bits for non-selected channels are ignored.
- MF lookup:
  - MF = SubPS[index] at the accept edge.
  - Write-first bypass: if TBL_WE and TBL_WADDR==index in the same cycle, MF = TBL_WDATA.
- Table write:
  - Takes effect at the posedge where TBL_WE=1.
  - Writes are independent of the handshake and allowed whether or not a transfer occurs.
  - A later packet to the same index sees the new value.
- Bits of PACKET_IN other than MF_BIT pass unmodified. The select field is preserved except where it overlaps MF_BIT; with the defaults, the MF overwrite replaces the BR bit.
- No internal state other than: SubPS, output register, V, ch, DROP_CNT.

Test Plan:
1. Reset and basic route:
   - Stimulus: hold MR=0 two cycles; write SubPS[1]=1; send packet with dest=1, bit18(sel)=1, other bits 0x2A_5555_AAAA & mask, Ack_in=2'b11.
   - Response: Send_out=2'b10 one cycle after accept; PACKET_OUT bit18=1; all other bits equal the input.
2. MF clear and channel 0:
   - Stimulus: dest=5 (SubPS[5]=0 after reset), sel=0.
   - Response: Send_out=2'b01; bit18=0.
3. Backpressure:
   - Stimulus: Ack_in=0 for 3 cycles after the packet is presented.
   - Response: PACKET_OUT/Send_out stable for 3 cycles; Ack_out=0; a second input packet is not accepted until the drain edge, then loads on that same edge with no bubble.
4. Streaming:
   - Stimulus: 8 back-to-back packets, alternating sel 0/1, Ack_in=2'b11.
   - Response: one output per cycle, in order, Ack_out continuously 1.
5. Write bypass:
   - Stimulus: in the same cycle, TBL_WE=1, TBL_WADDR=3, TBL_WDATA=1, and accept packet with dest=3.
   - Response: output bit MF_BIT=1. A second packet to dest=3 also gives MF=1.
6. Drop and reset mid-transfer:
   - Stimulus: NCH=3, SEL_W=2; send sel=3 three times.
   - Response: DROP_CNT=3; no Send_out. Then assert MR=0 while Send_out is stalled: next cycle Send_out=0 and DROP_CNT=0; SubPS[3] reads 0 afterwards.

Source files
------------

// File: rtl/branch_stage_n.sv
// Single-clock branch stage. It looks up a per-destination match flag (MF),
// writes it into the packet, and routes the packet to one of NCH Send/Ack channels.
module branch_stage_n #(
  parameter int PW       = 38,
  parameter int DEST_LSB = 20,
  parameter int TBL_AW   = 6,
  parameter int SEL_LSB  = 18,
  parameter int SEL_W    = 1,
  parameter int NCH      = 2,
  parameter int MF_BIT   = 18
) (
  input  logic              CP,
  input  logic              MR,
  input  logic [PW-1:0]     PACKET_IN,
  input  logic              Send_in,
  output logic              Ack_out,
  output logic [PW-1:0]     PACKET_OUT,
  output logic [NCH-1:0]    Send_out,
  input  logic [NCH-1:0]    Ack_in,
  input  logic              TBL_WE,
  input  logic [TBL_AW-1:0] TBL_WADDR,
  input  logic              TBL_WDATA,
  output logic [15:0]       DROP_CNT
);
  localparam int DEPTH = 1 << TBL_AW;
  localparam logic [SEL_W:0] NCH_L = (SEL_W+1)'(NCH);

  logic [DEPTH-1:0]  tbl_q;
  logic              v_q;
  logic [SEL_W-1:0]  ch_q;
  logic [PW-1:0]     pkt_q, pkt_d;
  logic [15:0]       drop_q;

  logic [TBL_AW-1:0] idx;
  logic [SEL_W-1:0]  sel;
  logic              mf, sel_ok, drain, accept;

  assign idx    = PACKET_IN[DEST_LSB +: TBL_AW];
  assign sel    = PACKET_IN[SEL_LSB +: SEL_W];
  assign sel_ok = {1'b0, sel} < NCH_L;

  // A write to the entry being looked up in the same cycle takes priority.
  assign mf = (TBL_WE && (TBL_WADDR == idx)) ? TBL_WDATA : tbl_q[idx];

  always_comb begin
    pkt_d         = PACKET_IN;
    pkt_d[MF_BIT] = mf;
  end

  for (genvar k = 0; k < NCH; k++) begin : g_send
    assign Send_out[k] = v_q && (ch_q == SEL_W'(k));
  end

  // Only the selected channel's Ack can drain, since Send_out is one-hot.
  assign drain   = |(Send_out & Ack_in);
  assign Ack_out = MR & (~v_q | drain);
  assign accept  = Send_in & Ack_out;

  always_ff @(posedge CP) begin
    if (!MR) begin
      tbl_q  <= '0;
      v_q    <= 1'b0;
      ch_q   <= '0;
      pkt_q  <= '0;
      drop_q <= '0;
    end else begin
      if (TBL_WE) tbl_q[TBL_WADDR] <= TBL_WDATA;
      if (accept) begin
        if (sel_ok) begin
          v_q   <= 1'b1;
          ch_q  <= sel;
          pkt_q <= pkt_d;
        end else begin
          v_q <= 1'b0;
          if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
        end
      end else if (drain) begin
        v_q <= 1'b0;
      end
    end
  end

  assign PACKET_OUT = pkt_q;
  assign DROP_CNT   = drop_q;
endmodule

// File: tb/tb_branch_stage_n.sv
// Bench for branch_stage_n: a default 2-channel instance, plus a 3-channel
// instance that exercises the discard path.
module tb_branch_stage_n;
  localparam int PW = 38;

  logic CP = 1'b0;
  always #5 CP = ~CP;

  // Instance A: defaults (NCH=2, SEL_W=1)
  logic          a_mr, a_send, a_ack_out, a_we, a_wdata;
  logic [PW-1:0] a_pkt, a_pkt_out;
  logic [1:0]    a_send_out, a_ack;
  logic [5:0]    a_waddr;
  logic [15:0]   a_drop;

  // Instance B: NCH=3, SEL_W=2
  logic          b_mr, b_send, b_ack_out, b_we, b_wdata;
  logic [PW-1:0] b_pkt, b_pkt_out;
  logic [2:0]    b_send_out, b_ack;
  logic [5:0]    b_waddr;
  logic [15:0]   b_drop;

  branch_stage_n u_a (
    .CP(CP), .MR(a_mr), .PACKET_IN(a_pkt), .Send_in(a_send), .Ack_out(a_ack_out),
    .PACKET_OUT(a_pkt_out), .Send_out(a_send_out), .Ack_in(a_ack),
    .TBL_WE(a_we), .TBL_WADDR(a_waddr), .TBL_WDATA(a_wdata), .DROP_CNT(a_drop));

  branch_stage_n #(.NCH(3), .SEL_W(2)) u_b (
    .CP(CP), .MR(b_mr), .PACKET_IN(b_pkt), .Send_in(b_send), .Ack_out(b_ack_out),
    .PACKET_OUT(b_pkt_out), .Send_out(b_send_out), .Ack_in(b_ack),
    .TBL_WE(b_we), .TBL_WADDR(b_waddr), .TBL_WDATA(b_wdata), .DROP_CNT(b_drop));

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state for instance A: SubPS contents plus expected/observed delivery streams.
  bit               mdl_tbl [64];
  logic [PW:0]      exp_q [$];
  logic [PW:0]      obs_q [$];

  function automatic logic [PW-1:0] exp_pkt(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    r     = p;
    r[18] = mdl_tbl[p[25:20]];
    return r;
  endfunction

  function automatic logic [PW-1:0] mk_pkt(input logic [5:0] dest, input logic [1:0] sel);
    logic [PW-1:0] r;
    r       = {$urandom, $urandom};
    r[25:20] = dest;
    r[19:18] = sel;
    return r;
  endfunction

  // Record every packet that actually leaves instance A (valid & ack ahead of the edge).
  always @(negedge CP)
    if (a_mr && |(a_send_out & a_ack))
      obs_q.push_back({a_send_out[1], a_pkt_out});

  task automatic step;
    @(posedge CP);
    #1;
  endtask

  task automatic test_reset;
    a_mr = 1'b0; b_mr = 1'b0;
    a_pkt = mk_pkt(6'd2, 2'd1); a_send = 1'b1; a_ack = 2'b11;
    a_we = 1'b1; a_waddr = 6'd2; a_wdata = 1'b1;
    b_pkt = '0; b_send = 1'b0; b_ack = '0; b_we = 1'b0; b_waddr = '0; b_wdata = 1'b0;
    step; step;
    @(negedge CP);
    n_cmp++;
    if (a_send_out !== 2'b00) begin n_fail++; $display("FAIL reset_send_out got=%b want=00", a_send_out); end
    n_cmp++;
    if (a_pkt_out !== '0) begin n_fail++; $display("FAIL reset_packet_out got=%h want=0", a_pkt_out); end
    n_cmp++;
    if (a_drop !== 16'd0) begin n_fail++; $display("FAIL reset_drop_cnt got=%0d want=0", a_drop); end
    n_cmp++;
    if (a_ack_out !== 1'b0) begin n_fail++; $display("FAIL reset_ack_out got=%b want=0", a_ack_out); end
    foreach (mdl_tbl[i]) mdl_tbl[i] = 1'b0;
    a_send = 1'b0; a_we = 1'b0;
    step;
    a_mr = 1'b1; b_mr = 1'b1;
    step;
    // The write issued under reset must not have landed.
    a_pkt = mk_pkt(6'd2, 2'd0); a_send = 1'b1;
    step;
    a_send = 1'b0;
    @(negedge CP);
    n_cmp++;
    if (a_pkt_out[18] !== 1'b0) begin n_fail++; $display("FAIL reset_tbl_cleared got=%b want=0", a_pkt_out[18]); end
    step;
  endtask

  task automatic test_basic_route;
    logic [PW-1:0] p;
    a_we = 1'b1; a_waddr = 6'd1; a_wdata = 1'b1; mdl_tbl[1] = 1'b1;
    step;
    a_we = 1'b0;
    p = 38'h2A_5555_AAAA;
    p[25:20] = 6'd1; p[18] = 1'b1;
    a_pkt = p; a_send = 1'b1; a_ack = 2'b11;
    step;
    a_send = 1'b0;
    @(negedge CP);
    n_cmp++;
    if (a_send_out !== 2'b10) begin n_fail++; $display("FAIL route_send_out got=%b want=10", a_send_out); end
    n_cmp++;
    if (a_pkt_out !== p) begin n_fail++; $display("FAIL route_packet got=%h want=%h", a_pkt_out, p); end
    step;
  endtask

  task automatic test_mf_ch0;
    logic [PW-1:0] p, w;
    p = mk_pkt(6'd5, 2'd0);
    w = p; w[18] = 1'b0;
    a_pkt = p; a_send = 1'b1; a_ack = 2'b11;
    step;
    a_send = 1'b0;
    @(negedge CP);
    n_cmp++;
    if (a_send_out !== 2'b01) begin n_fail++; $display("FAIL ch0_send_out got=%b want=01", a_send_out); end
    n_cmp++;
    if (a_pkt_out !== w) begin n_fail++; $display("FAIL ch0_packet got=%h want=%h", a_pkt_out, w); end
    step;
  endtask

  task automatic test_backpressure;
    logic [PW-1:0] p1, p2;
    p1 = mk_pkt(6'd1, 2'd0);
    p2 = mk_pkt(6'd9, 2'd1);
    a_ack = 2'b00; a_pkt = p1; a_send = 1'b1;
    step;
    a_pkt = p2;
    for (int k = 0; k < 3; k++) begin
      @(negedge CP);
      n_cmp++;
      if (a_send_out !== 2'b01 || a_pkt_out !== exp_pkt(p1) || a_ack_out !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold cyc=%0d got send=%b pkt=%h ack=%b want send=01 pkt=%h ack=0",
                 k, a_send_out, a_pkt_out, a_ack_out, exp_pkt(p1));
      end
      step;
    end
    a_ack = 2'b01;
    @(negedge CP);
    n_cmp++;
    if (a_ack_out !== 1'b1) begin n_fail++; $display("FAIL drain_ack_out got=%b want=1", a_ack_out); end
    step;
    a_send = 1'b0;
    @(negedge CP);
    n_cmp++;
    if (a_send_out !== 2'b10 || a_pkt_out !== exp_pkt(p2)) begin
      n_fail++;
      $display("FAIL no_bubble got send=%b pkt=%h want send=10 pkt=%h", a_send_out, a_pkt_out, exp_pkt(p2));
    end
    a_ack = 2'b11;
    step; step;
  endtask

  task automatic test_streaming;
    logic [PW-1:0] p;
    obs_q.delete(); exp_q.delete();
    a_ack = 2'b11;
    for (int i = 0; i < 8; i++) begin
      p = mk_pkt(6'($urandom_range(0, 63)), 2'(i % 2));
      a_pkt = p; a_send = 1'b1;
      @(negedge CP);
      n_cmp++;
      if (a_ack_out !== 1'b1) begin n_fail++; $display("FAIL stream_ack_out i=%0d got=%b want=1", i, a_ack_out); end
      if (i > 0) begin
        n_cmp++;
        if (a_send_out !== ((i % 2 == 1) ? 2'b01 : 2'b10)) begin
          n_fail++; $display("FAIL stream_rate i=%0d got=%b", i, a_send_out);
        end
      end
      exp_q.push_back({p[18], exp_pkt(p)});
      step;
    end
    a_send = 1'b0;
    step; step;
    n_cmp++;
    if (obs_q.size() != 8) begin n_fail++; $display("FAIL stream_count got=%0d want=8", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [PW:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL stream_order got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_write_bypass;
    logic [PW-1:0] p;
    p = mk_pkt(6'd3, 2'd0);
    a_we = 1'b1; a_waddr = 6'd3; a_wdata = 1'b1; mdl_tbl[3] = 1'b1;
    a_pkt = p; a_send = 1'b1; a_ack = 2'b11;
    step;
    a_we = 1'b0;
    p = mk_pkt(6'd3, 2'd0);
    a_pkt = p;
    @(negedge CP);
    n_cmp++;
    if (a_pkt_out[18] !== 1'b1 || a_send_out !== 2'b01) begin
      n_fail++; $display("FAIL bypass_mf got mf=%b send=%b want mf=1 send=01", a_pkt_out[18], a_send_out);
    end
    step;
    a_send = 1'b0;
    @(negedge CP);
    n_cmp++;
    if (a_pkt_out[18] !== 1'b1) begin n_fail++; $display("FAIL bypass_later_mf got=%b want=1", a_pkt_out[18]); end
    step;
  endtask

  task automatic test_random;
    logic [PW-1:0] p;
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 200; i++) begin
      p = mk_pkt(6'($urandom_range(0, 63)), 2'($urandom_range(0, 1)));
      a_pkt   = p;
      a_send  = ($urandom_range(0, 3) != 0);
      a_ack   = 2'($urandom);
      a_we    = ($urandom_range(0, 2) == 0);
      a_waddr = $urandom_range(0, 1) ? p[25:20] : 6'($urandom);
      a_wdata = 1'($urandom);
      @(negedge CP);
      if (a_we) mdl_tbl[a_waddr] = a_wdata;
      if (a_send && a_ack_out) exp_q.push_back({p[18], exp_pkt(p)});
      step;
    end
    a_send = 1'b0; a_we = 1'b0; a_ack = 2'b11;
    step; step; step;
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [PW:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL rand_pkt got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_drop_and_reset;
    logic [PW-1:0] p;
    b_ack = 3'b000;
    for (int i = 0; i < 3; i++) begin
      b_pkt = mk_pkt(6'($urandom_range(0, 63)), 2'd3); b_send = 1'b1;
      step;
      b_send = 1'b0;
      @(negedge CP);
      n_cmp++;
      if (b_send_out !== 3'b000) begin n_fail++; $display("FAIL drop_no_send i=%0d got=%b want=000", i, b_send_out); end
    end
    n_cmp++;
    if (b_drop !== 16'd3) begin n_fail++; $display("FAIL drop_cnt got=%0d want=3", b_drop); end
    step;
    b_we = 1'b1; b_waddr = 6'd3; b_wdata = 1'b1;
    step;
    b_we = 1'b0;
    p = mk_pkt(6'd3, 2'd2);
    b_pkt = p; b_send = 1'b1;
    step;
    b_send = 1'b0;
    step;
    @(negedge CP);
    n_cmp++;
    if (b_send_out !== 3'b100 || b_pkt_out[18] !== 1'b1) begin
      n_fail++; $display("FAIL b_stalled got send=%b mf=%b want send=100 mf=1", b_send_out, b_pkt_out[18]);
    end
    step;
    b_mr = 1'b0;
    step;
    b_mr = 1'b1;
    @(negedge CP);
    n_cmp++;
    if (b_send_out !== 3'b000 || b_drop !== 16'd0 || b_pkt_out !== '0) begin
      n_fail++; $display("FAIL b_reset got send=%b drop=%0d pkt=%h want 000/0/0", b_send_out, b_drop, b_pkt_out);
    end
    step;
    b_pkt = p; b_send = 1'b1; b_ack = 3'b111;
    step;
    b_send = 1'b0;
    @(negedge CP);
    n_cmp++;
    if (b_send_out !== 3'b100 || b_pkt_out[18] !== 1'b0) begin
      n_fail++; $display("FAIL b_tbl_cleared got send=%b mf=%b want send=100 mf=0", b_send_out, b_pkt_out[18]);
    end
    step;
  endtask

  initial begin
    test_reset;
    test_basic_route;
    test_mf_ch0;
    test_backpressure;
    test_streaming;
    test_write_bypass;
    test_random;
    test_drop_and_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end
endmodule
